xillybus_ev_out_fifo: RTL

XILLYBUS_EV_OUT_FIFO -- requirements
Module: xillybus_ev_out_fifo

---
 rtl/xillybus_ev_out_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/xillybus_ev_out_fifo.sv
// Event-word FIFO between an event builder and a Xillybus read stream.
// Each event's last word can raise end-of-file on the host side.
module xillybus_ev_out_fifo #(
  parameter int unsigned DEPTH_LOG2    = 10,
  parameter bit          EOF_PER_EVENT = 1'b1
) (
  input  logic                  bus_clk,
  input  logic                  trn_reset_n,
  input  logic                  ev_wr_en,
  input  logic [15:0]           ev_wr_dat,
  input  logic                  ev_wr_last,
  output logic                  ev_full,
  output logic [DEPTH_LOG2:0]   ev_count,
  output logic                  ev_ovf,
  input  logic                  ev_ovf_clr,
  input  logic                  user_r_ev_out_rden,
  output logic [15:0]           user_r_ev_out_data,
  output logic                  user_r_ev_out_empty,
  output logic                  user_r_ev_out_eof,
  input  logic                  user_r_ev_out_open
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, STREAM, EOF_HOLD} state_t;

  logic [16:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic [16:0]           rd_entry;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  open_q;
  logic                  empty_next;
  logic                  eof_next;
  state_t                state;
  state_t                state_next;

  assign ev_full   = (count == FULL_COUNT);
  assign ev_count  = count;
  assign wr_accept = ev_wr_en & ~ev_full;
  // empty is registered and already reflects read-side state, so it alone gates reads
  assign rd_accept = user_r_ev_out_rden & ~user_r_ev_out_empty;
  assign rd_entry  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (user_r_ev_out_open && !open_q) state_next = STREAM;
      end
      STREAM: begin
        if (!user_r_ev_out_open)
          state_next = IDLE;
        else if (EOF_PER_EVENT && rd_accept && rd_entry[16])
          state_next = EOF_HOLD;
      end
      EOF_HOLD: begin
        if (!user_r_ev_out_open) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flags are computed from the post-edge count so a read draining the last word raises empty at once
  always_comb begin
    empty_next = 1'b1;
    eof_next   = 1'b0;
    if (state_next == STREAM) empty_next = (count_next == '0);
    if (state_next == EOF_HOLD) eof_next = 1'b1;
  end

  always_ff @(posedge bus_clk) begin
    if (wr_accept) mem[wr_ptr] <= {ev_wr_last, ev_wr_dat};
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state               <= IDLE;
      open_q              <= 1'b0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      ev_ovf              <= 1'b0;
      user_r_ev_out_data  <= '0;
      user_r_ev_out_empty <= 1'b1;
      user_r_ev_out_eof   <= 1'b0;
    end else begin
      state               <= state_next;
      open_q              <= user_r_ev_out_open;
      count               <= count_next;
      user_r_ev_out_empty <= empty_next;
      user_r_ev_out_eof   <= eof_next;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) begin
        rd_ptr             <= rd_ptr + 1'b1;
        user_r_ev_out_data <= rd_entry[15:0];
      end
      if (ev_wr_en && ev_full)
        ev_ovf <= 1'b1;
      else if (ev_ovf_clr)
        ev_ovf <= 1'b0;
    end
  end

endmodule
